sd_block_cache: RTL and testbench

//  Direct-mapped, write-back, multi-line cache of SD-card blocks in front of the SPI SD controller.

---
 rtl/sd_block_cache.sv | 205 ++++++++++++++++++++
 tb/tb_sd_block_cache.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_cache.sv
// Direct-mapped write-back cache of SD blocks between the CPU and the SPI block engine.
// Fetches missing blocks, evicts dirty victims, and flushes all dirty lines on request.
module sd_block_cache #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_SHIFT = 9,
  parameter int LINE_W      = 2,
  localparam int BW         = ADDR_W - BLOCK_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic              busy,
  output logic              read_spi,
  output logic              write_spi,
  output logic [BW-1:0]     spi_block,
  output logic [LINE_W-1:0] spi_line,
  output logic [LINE_W-1:0] ram_line,
  output logic              write_ram,
  output logic              ready,
  output logic              flush_done
);

  localparam int LINES = 2 ** LINE_W;
  localparam logic [LINE_W-1:0] LAST = LINE_W'(LINES - 1);

  typedef enum logic [2:0] {
    IDLE, HIT_RD, HIT_WR, EVICT_WAIT, FILL_WAIT, FLUSH_SCAN, FLUSH_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              guard_q, guard_d;
  logic [LINE_W-1:0] ptr_q, ptr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [BW-1:0]     tag_q [LINES];
  logic [BW-1:0]     tag_d [LINES];
  logic              read_spi_q, read_spi_d;
  logic              write_spi_q, write_spi_d;
  logic [BW-1:0]     spi_block_q, spi_block_d;
  logic [LINE_W-1:0] spi_line_q, spi_line_d;
  logic              write_ram_q, write_ram_d;
  logic              ready_q, ready_d;
  logic              flush_done_q, flush_done_d;

  logic [BW-1:0]     block;
  logic [LINE_W-1:0] idx;
  logic              hit;
  logic              unused_addr;

  assign block       = addr[ADDR_W-1:BLOCK_SHIFT];
  assign idx         = block[LINE_W-1:0];
  assign hit         = valid_q[idx] && (tag_q[idx] == block);
  assign unused_addr = ^addr[BLOCK_SHIFT-1:0];

  assign ram_line   = idx;
  assign read_spi   = read_spi_q;
  assign write_spi  = write_spi_q;
  assign spi_block  = spi_block_q;
  assign spi_line   = spi_line_q;
  assign write_ram  = write_ram_q;
  assign ready      = ready_q;
  assign flush_done = flush_done_q;

  // Next-state, line bookkeeping and registered output decode.
  always_comb begin
    state_d      = state_q;
    guard_d      = guard_q;
    ptr_d        = ptr_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    spi_block_d  = spi_block_q;
    spi_line_d   = spi_line_q;
    read_spi_d   = 1'b0;
    write_spi_d  = 1'b0;
    write_ram_d  = 1'b0;
    ready_d      = 1'b0;
    flush_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A request is still held in the cycle its completion pulse shows.
        if (!ready_q && !flush_done_q) begin
          if (read || write) begin
            if (hit) begin
              state_d = write ? HIT_WR : HIT_RD;
            end else if (valid_q[idx] && dirty_q[idx]) begin
              write_spi_d = 1'b1;
              spi_block_d = tag_q[idx];
              spi_line_d  = idx;
              guard_d     = 1'b1;
              state_d     = EVICT_WAIT;
            end else begin
              read_spi_d  = 1'b1;
              spi_block_d = block;
              spi_line_d  = idx;
              guard_d     = 1'b1;
              state_d     = FILL_WAIT;
            end
          end else if (flush) begin
            ptr_d   = '0;
            state_d = FLUSH_SCAN;
          end
        end
      end
      HIT_RD: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      HIT_WR: begin
        ready_d      = 1'b1;
        write_ram_d  = 1'b1;
        dirty_d[idx] = 1'b1;
        state_d      = IDLE;
      end
      EVICT_WAIT: begin
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!busy) begin
          dirty_d[idx] = 1'b0;
          read_spi_d   = 1'b1;
          spi_block_d  = block;
          spi_line_d   = idx;
          guard_d      = 1'b1;
          state_d      = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!busy) begin
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          tag_d[idx]   = block;
          state_d      = IDLE;
        end
      end
      FLUSH_SCAN: begin
        if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
          write_spi_d = 1'b1;
          spi_block_d = tag_q[ptr_q];
          spi_line_d  = ptr_q;
          guard_d     = 1'b1;
          state_d     = FLUSH_WAIT;
        end else if (ptr_q == LAST) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      FLUSH_WAIT: begin
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!busy) begin
          dirty_d[ptr_q] = 1'b0;
          if (ptr_q == LAST) begin
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = FLUSH_SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, line metadata and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      guard_q      <= 1'b0;
      ptr_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      tag_q        <= '{default: '0};
      read_spi_q   <= 1'b0;
      write_spi_q  <= 1'b0;
      spi_block_q  <= '0;
      spi_line_q   <= '0;
      write_ram_q  <= 1'b0;
      ready_q      <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      ptr_q        <= ptr_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      read_spi_q   <= read_spi_d;
      write_spi_q  <= write_spi_d;
      spi_block_q  <= spi_block_d;
      spi_line_q   <= spi_line_d;
      write_ram_q  <= write_ram_d;
      ready_q      <= ready_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_sd_block_cache.sv
// Scoreboard bench for sd_block_cache: a reference cache model queues the
// expected SPI/CPU events, a monitor pops and compares them as they occur.
module tb_sd_block_cache;

  localparam int BW = 23;
  localparam int LW = 2;
  localparam logic [2:0] K_RD  = 3'd1;
  localparam logic [2:0] K_WR  = 3'd2;
  localparam logic [2:0] K_RDY = 3'd3;
  localparam logic [2:0] K_FD  = 3'd4;

  typedef struct packed {
    logic [2:0]    kind;
    logic          wr;
    logic [BW-1:0] blk;
    logic [LW-1:0] line;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst, read, write, flush, busy;
  logic [31:0]   addr;
  logic          read_spi, write_spi, write_ram, ready, flush_done;
  logic [BW-1:0] spi_block;
  logic [LW-1:0] spi_line, ram_line;

  ev_t           exp_q [$];
  int            checks = 0;
  int            failures = 0;
  int            spi_len = 5;
  int            cyc;

  logic          m_valid [4];
  logic          m_dirty [4];
  logic [BW-1:0] m_tag [4];

  sd_block_cache dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .flush(flush),
    .addr(addr), .busy(busy), .read_spi(read_spi), .write_spi(write_spi),
    .spi_block(spi_block), .spi_line(spi_line), .ram_line(ram_line),
    .write_ram(write_ram), .ready(ready), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic [2:0] k, input logic wr,
                               input logic [BW-1:0] b, input logic [LW-1:0] l);
    ev_t e;
    e.kind = k; e.wr = wr; e.blk = b; e.line = l;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
  endfunction

  function automatic void model_access(input logic wr, input logic [31:0] a);
    logic [BW-1:0] b;
    int i;
    b = a[31:9];
    i = int'(b[1:0]);
    if (!(m_valid[i] && m_tag[i] == b)) begin
      if (m_valid[i] && m_dirty[i]) push(K_WR, 1'b0, m_tag[i], LW'(i));
      push(K_RD, 1'b0, b, LW'(i));
      m_valid[i] = 1'b1; m_tag[i] = b; m_dirty[i] = 1'b0;
    end
    push(K_RDY, wr, '0, LW'(i));
    if (wr) m_dirty[i] = 1'b1;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        push(K_WR, 1'b0, m_tag[i], LW'(i));
        m_dirty[i] = 1'b0;
      end
    end
    push(K_FD, 1'b0, '0, '0);
  endfunction

  task automatic observe(input ev_t got);
    ev_t e;
    string tag;
    if (exp_q.size() == 0) begin
      chk("spurious_event", got, '0);
    end else begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RD:    tag = "read_spi";
        K_WR:    tag = "write_spi";
        K_RDY:   tag = "ready";
        default: tag = "flush_done";
      endcase
      chk(tag, got, e);
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_spi)  observe({K_RD, 1'b0, spi_block, spi_line});
      if (write_spi) observe({K_WR, 1'b0, spi_block, spi_line});
      if (ready)     observe({K_RDY, write_ram, {BW{1'b0}}, ram_line});
      else if (write_ram) chk("stray_write_ram", write_ram, 1'b0);
      if (flush_done) observe({K_FD, 1'b0, {BW{1'b0}}, {LW{1'b0}}});
    end
  end

  // SPI engine stand-in: busy rises in the pulse cycle, holds spi_len cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if ((read_spi || write_spi) && !rst) begin
        busy = 1'b1;
        repeat (spi_len) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  task automatic cpu_req(input logic rd, input logic wr,
                         input logic [31:0] a, output int n);
    model_access(wr, a);
    @(negedge clk);
    addr = a; read = rd; write = wr; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 300);
    if (!ready) chk("req_timeout", 1'b0, 1'b1);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_flush();
    int n;
    model_flush();
    @(negedge clk);
    flush = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!flush_done && n < 300);
    if (!flush_done) chk("flush_timeout", 1'b0, 1'b1);
    flush = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    rst = 1'b1; read = 1'b0; write = 1'b0; flush = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {read_spi, write_spi, write_ram, ready, flush_done,
                       spi_block, spi_line, ram_line}, '0);
    rst = 1'b0;

    // 1: cold miss fills line 1 from block 1
    cpu_req(1'b1, 1'b0, 32'h200, cyc);
    chk("miss_slower", 64'(cyc > 2), 1);
    chk("spi_block_hold", spi_block, 1);
    chk("spi_line_hold", spi_line, 1);

    // 2: same address now hits in exactly 2 cycles
    cpu_req(1'b1, 1'b0, 32'h200, cyc);
    chk("hit_latency", cyc, 2);

    // 3: dirty line 1 evicted by block 9
    cpu_req(1'b0, 1'b1, 32'h200, cyc);
    chk("write_hit_latency", cyc, 2);
    cpu_req(1'b1, 1'b0, 32'h1200, cyc);

    // 4: dirty lines 0 and 2 (read+write together counts as write), flush
    cpu_req(1'b1, 1'b1, 32'h000, cyc);
    cpu_req(1'b0, 1'b1, 32'h400, cyc);
    do_flush();
    cpu_req(1'b1, 1'b0, 32'h000, cyc);
    chk("valid_after_flush", cyc, 2);

    // 6: read and flush raised together; read served first
    cpu_req(1'b0, 1'b1, 32'h600, cyc);
    model_access(1'b0, 32'h400);
    model_flush();
    @(negedge clk);
    addr = 32'h400; read = 1'b1; flush = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < 300);
    if (!ready) chk("t6_ready_timeout", 1'b0, 1'b1);
    read = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (!flush_done && n < 300);
    if (!flush_done) chk("t6_flush_timeout", 1'b0, 1'b1);
    flush = 1'b0;

    // 5: reset during FILL_WAIT abandons the fill
    model_access(1'b0, 32'h800);
    @(negedge clk);
    addr = 32'h800; read = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!read_spi && n < 50);
    if (!read_spi) chk("t5_fill_timeout", 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("rst_mid_fill", {read_spi, write_spi, write_ram, ready, flush_done,
                         spi_block, spi_line}, '0);
    read = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    cpu_req(1'b1, 1'b0, 32'h800, cyc);
    chk("refetch_after_rst", 64'(cyc > 2), 1);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
